avalon_ecc_interface: RTL and testbench

- Avalon-MM slave wrapper for the ECC core, directly upstream of the top-level hex display path.
- Holds operand registers for software (NIOS via Qsys) and drives a start/done handshake to the ECC arithmetic core.
- Captures the core result, counts run cycles, and drives the 32-bit export data that feeds the eight hex drivers.

---
 rtl/avalon_ecc_interface.sv | 148 ++++++++++++++
 tb/tb_avalon_ecc_interface.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/avalon_ecc_interface.sv
// Avalon-MM register wrapper around the ECC arithmetic core: operand/result registers,
// start/done/abort handshake, run-cycle counter and hex export word. `ECC_IRQ_EN adds irq.
//
// state  | meaning
// IDLE   | waiting for software to set reg14[0]
// RUN    | core busy, operands locked, cycle counter running
// DONE   | result captured, reg15[0] set until reg14[0] is cleared
module avalon_ecc_interface #(
  parameter int DATA_W   = 32,
  parameter int OP_WORDS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         AVL_CS,
  input  logic                         AVL_READ,
  input  logic                         AVL_WRITE,
  input  logic [3:0]                   AVL_ADDR,
  input  logic [3:0]                   AVL_BYTE_EN,
  input  logic [DATA_W-1:0]            AVL_WRITEDATA,
  output logic [DATA_W-1:0]            AVL_READDATA,
  output logic [OP_WORDS*DATA_W-1:0]   core_op_a,
  output logic [OP_WORDS*DATA_W-1:0]   core_op_b,
  output logic                         core_start,
  output logic                         core_abort,
  input  logic                         core_done,
  input  logic [OP_WORDS*DATA_W-1:0]   core_result,
`ifdef ECC_IRQ_EN
  output logic                         irq,
`endif
  output logic [DATA_W-1:0]            EXPORT_DATA
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  op_q [2*OP_WORDS];
  logic [DATA_W-1:0]  res_q [OP_WORDS];
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  scratch_q;
  logic [DATA_W-1:0]  ctrl_q;
  logic               done_q;
  logic               wr, rd, go_eff, start_d, abort_d, capture;
  logic [DATA_W-1:0]  ctrl_wr, rd_mux;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [3:0]        be);
    merge_bytes = old_v;
    for (int b = 0; b < DATA_W/8; b++)
      if (be[b]) merge_bytes[8*b +: 8] = new_v[8*b +: 8];
  endfunction

  assign wr      = AVL_CS & AVL_WRITE;
  assign rd      = AVL_CS & AVL_READ;
  assign ctrl_wr = merge_bytes(ctrl_q, AVL_WRITEDATA, AVL_BYTE_EN);
  // A clear of reg14 that lands this cycle must beat a simultaneous core_done.
  assign go_eff  = (wr && AVL_ADDR == 4'd14) ? ctrl_wr[0] : ctrl_q[0];

  for (genvar w = 0; w < OP_WORDS; w++) begin : g_ops
    assign core_op_a[w*DATA_W +: DATA_W] = op_q[w];
    assign core_op_b[w*DATA_W +: DATA_W] = op_q[w+OP_WORDS];
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (ctrl_q[0]) begin
        state_d = S_RUN;
        start_d = 1'b1;
      end
      S_RUN: if (!go_eff) begin
        state_d = S_IDLE;
        abort_d = 1'b1;
      end else if (core_done) begin
        state_d = S_DONE;
        capture = 1'b1;
      end
      S_DONE: if (!ctrl_q[0]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (AVL_ADDR)
      4'd12:   rd_mux = DATA_W'(cnt_q);
      4'd13:   rd_mux = scratch_q;
      4'd14:   rd_mux = ctrl_q;
      4'd15:   rd_mux = DATA_W'(done_q);
      default: rd_mux = AVL_ADDR[3] ? res_q[AVL_ADDR[1:0]] : op_q[AVL_ADDR[2:0]];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < 2*OP_WORDS; i++) op_q[i] <= '0;
      for (int i = 0; i < OP_WORDS; i++) res_q[i] <= '0;
      cnt_q        <= '0;
      scratch_q    <= '0;
      ctrl_q       <= '0;
      done_q       <= 1'b0;
      core_start   <= 1'b0;
      core_abort   <= 1'b0;
      AVL_READDATA <= '0;
      EXPORT_DATA  <= '0;
`ifdef ECC_IRQ_EN
      irq          <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      core_start <= start_d;
      core_abort <= abort_d;

      if (wr) begin
        if (!AVL_ADDR[3] && state_q != S_RUN)
          op_q[AVL_ADDR[2:0]] <= merge_bytes(op_q[AVL_ADDR[2:0]], AVL_WRITEDATA, AVL_BYTE_EN);
        if (AVL_ADDR == 4'd13)
          scratch_q <= merge_bytes(scratch_q, AVL_WRITEDATA, AVL_BYTE_EN);
        if (AVL_ADDR == 4'd14)
          ctrl_q <= ctrl_wr;
      end

      if (start_d)
        cnt_q <= '0;
      else if (state_q == S_RUN && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;

      if (capture) begin
        for (int i = 0; i < OP_WORDS; i++) res_q[i] <= core_result[i*DATA_W +: DATA_W];
        done_q <= 1'b1;
      end else if (state_q == S_DONE && state_d == S_IDLE) begin
        done_q <= 1'b0;
      end

      if (rd) AVL_READDATA <= rd_mux;
      EXPORT_DATA <= done_q ? res_q[0] : op_q[0];
`ifdef ECC_IRQ_EN
      irq <= scratch_q[0] & done_q;
`endif
    end
  end

endmodule

// File: tb/tb_avalon_ecc_interface.sv
// Directed bench for avalon_ecc_interface: register map, byte enables, run/abort handshake
// and export word. Inputs driven and outputs sampled on the falling edge.
module tb_avalon_ecc_interface;

  logic         CLK = 1'b0;
  logic         RESET, AVL_CS, AVL_READ, AVL_WRITE, core_done;
  logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA, EXPORT_DATA;
  logic [127:0] core_op_a, core_op_b, core_result;
  logic         core_start, core_abort;
`ifdef ECC_IRQ_EN
  logic         irq;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rdata;

  avalon_ecc_interface dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .core_op_a(core_op_a), .core_op_b(core_op_b),
    .core_start(core_start), .core_abort(core_abort), .core_done(core_done),
    .core_result(core_result),
`ifdef ECC_IRQ_EN
    .irq(irq),
`endif
    .EXPORT_DATA(EXPORT_DATA)
  );

  always #10 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge with the bus idle.
  task automatic avl_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = addr; AVL_WRITEDATA = data; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic avl_read(input logic [3:0] addr, output logic [31:0] data);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = addr;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    data = AVL_READDATA;
  endtask

  initial begin
    RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_ADDR = '0;
    AVL_BYTE_EN = '0; AVL_WRITEDATA = '0; core_done = 1'b0; core_result = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    check_val("rst_export", EXPORT_DATA, 32'h0);
    check_val("rst_start", core_start, 1'b0);
    check_val("rst_abort", core_abort, 1'b0);
    check_val("rst_rdata", AVL_READDATA, 32'h0);
    for (int a = 0; a < 16; a++) begin
      avl_read(a[3:0], rdata);
      check_val($sformatf("rst_reg%0d", a), rdata, 32'h0);
    end

    // byte enables, read-only drop, scratch, read/write collision
    avl_write(4'd2, 32'hDEADBEEF, 4'b0101);
    avl_read(4'd2, rdata);
    check_val("be_write", rdata, 32'h00AD00EF);
    @(negedge CLK);
    check_val("rdata_hold", AVL_READDATA, 32'h00AD00EF);
    avl_write(4'd9, 32'h12345678, 4'hF);
    avl_read(4'd9, rdata);
    check_val("ro_drop", rdata, 32'h0);
    avl_write(4'd13, 32'hA5A5A5A5, 4'hF);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 4'd13;
    AVL_WRITEDATA = 32'h0; AVL_BYTE_EN = 4'hF;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    check_val("rw_same_old", AVL_READDATA, 32'hA5A5A5A5);
    avl_read(4'd13, rdata);
    check_val("rw_same_new", rdata, 32'h0);

    // full run: A=1, B=2, done after 10 run cycles
    avl_write(4'd0, 32'h1, 4'hF);
    avl_write(4'd2, 32'h0, 4'hF);
    avl_write(4'd4, 32'h2, 4'hF);
    check_val("op_a", core_op_a, 128'h1);
    check_val("op_b", core_op_b, 128'h2);
    check_val("export_reg0", EXPORT_DATA, 32'h1);
    avl_write(4'd14, 32'h1, 4'hF);
    check_val("start_pre", core_start, 1'b0);
    @(negedge CLK);
    check_val("start_pulse", core_start, 1'b1);
    avl_write(4'd0, 32'hFFFFFFFF, 4'hF);
    check_val("start_one_cycle", core_start, 1'b0);
    check_val("op_lock", core_op_a[31:0], 32'h1);
    repeat (8) @(negedge CLK);
    core_done = 1'b1; core_result = 128'h11112222_33334444_55556666_77778888;
    @(negedge CLK);
    core_done = 1'b0; core_result = '0;
    check_val("export_lag", EXPORT_DATA, 32'h1);
    @(negedge CLK);
    check_val("export_result", EXPORT_DATA, 32'h77778888);
    avl_read(4'd8, rdata);  check_val("res_w0", rdata, 32'h77778888);
    avl_read(4'd11, rdata); check_val("res_w3", rdata, 32'h11112222);
    avl_read(4'd15, rdata); check_val("done_set", rdata, 32'h1);
    avl_read(4'd12, rdata); check_val("run_cycles", rdata, 32'd10);
    avl_read(4'd0, rdata);  check_val("reg0_locked", rdata, 32'h1);

    avl_write(4'd14, 32'h0, 4'hF);
    repeat (2) @(negedge CLK);
    check_val("export_back", EXPORT_DATA, 32'h1);
    avl_read(4'd15, rdata); check_val("done_clr", rdata, 32'h0);
    avl_read(4'd8, rdata);  check_val("res_retained", rdata, 32'h77778888);

    // abort racing core_done: abort wins
    avl_write(4'd14, 32'h1, 4'hF);
    @(negedge CLK);
    check_val("start_pulse2", core_start, 1'b1);
    repeat (3) @(negedge CLK);
    core_done = 1'b1; core_result = {4{32'hAAAAAAAA}};
    avl_write(4'd14, 32'h0, 4'hF);
    core_done = 1'b0; core_result = '0;
    check_val("abort_pulse", core_abort, 1'b1);
    @(negedge CLK);
    check_val("abort_one_cycle", core_abort, 1'b0);
    avl_read(4'd8, rdata);  check_val("abort_res_w0", rdata, 32'h77778888);
    avl_read(4'd11, rdata); check_val("abort_res_w3", rdata, 32'h11112222);
    avl_read(4'd15, rdata); check_val("abort_done", rdata, 32'h0);
    avl_read(4'd12, rdata); check_val("abort_cycles", rdata, 32'd4);

    // core_done while idle is ignored
    core_done = 1'b1; core_result = {4{32'hBBBBBBBB}};
    @(negedge CLK);
    core_done = 1'b0; core_result = '0;
    avl_read(4'd8, rdata);  check_val("idle_done_res", rdata, 32'h77778888);
    avl_read(4'd15, rdata); check_val("idle_done_flag", rdata, 32'h0);
    check_val("idle_no_start", core_start, 1'b0);

`ifdef ECC_IRQ_EN
    avl_write(4'd13, 32'h1, 4'hF);
    avl_write(4'd14, 32'h1, 4'hF);
    @(negedge CLK);
    core_done = 1'b1; core_result = 128'h1;
    @(negedge CLK);
    core_done = 1'b0; core_result = '0;
    check_val("irq_lag", irq, 1'b0);
    @(negedge CLK);
    check_val("irq_set", irq, 1'b1);
    avl_write(4'd14, 32'h0, 4'hF);
    repeat (2) @(negedge CLK);
    check_val("irq_clr", irq, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
